// File: rtl/sr_drv_pkg.sv
// Shared types and defaults for the SR latch driver.
// Contents: FSM state enum, default pulse/gap widths, and the timer
// width helper.
// Optional macro: SR_LATCH_DRIVER_READBACK_EN adds the CHECK state.
package sr_drv_pkg;

  localparam int unsigned PULSE_CYC_DEF = 2;
  localparam int unsigned GAP_CYC_DEF   = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
`ifdef SR_LATCH_DRIVER_READBACK_EN
    ,
    ST_CHECK = 2'd3
`endif
  } drv_state_t;

  // One counter serves both phases, so it is sized for the larger of the two
  // load values. It is at least one bit wide so that a width of 1 is legal.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b);
    int unsigned w;
    w = $clog2(a);
    if ($clog2(b) > w) w = $clog2(b);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// Loadable down-counter with a zero flag. It times both the PULSE phase
// and the GAP phase.
// Ports: clk, rst (sync active-high), load/load_val (load a count),
//        zero (count is 0). The counter stops at 0 and does not wrap.
module sr_drv_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Drives an external SR latch with timed set/reset pulses.
// Each command produces a PULSE_CYC-wide pulse on s or r. A GAP_CYC
// both-low recovery period follows. done then pulses once, in the first
// IDLE cycle.
// Ports: clk, rst (sync active-high); cmd_valid/cmd_ready/cmd_set (command);
//        s, r (registered latch drives); q_fb, qbar_fb (latch readback);
//        done (one-cycle completion); err (sticky readback mismatch).
// Optional macro: SR_LATCH_DRIVER_READBACK_EN adds a one-cycle CHECK state
// that compares the latch readback against the command. Without the macro,
// err is tied to 0 and q_fb/qbar_fb are not used.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned PULSE_CYC = PULSE_CYC_DEF,
  parameter int unsigned GAP_CYC   = GAP_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_set,
  output logic s,
  output logic r,
  input  logic q_fb,
  input  logic qbar_fb,
  output logic done,
  output logic err
);

  localparam int unsigned CW = cnt_width(PULSE_CYC, GAP_CYC);
  // The timer counts N-1 down to 0, which gives N cycles in each phase.
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYC - 1);

  drv_state_t     state;
  logic           s_q, r_q, done_q;
  logic           tmr_load, tmr_zero;
  logic [CW-1:0]  tmr_val;

`ifdef SR_LATCH_DRIVER_READBACK_EN
  logic set_lat;
  logic err_q;
`endif

  // The timer is loaded on the same edges where the FSM enters PULSE or GAP.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = PULSE_LOAD;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          tmr_load = 1'b1;
          tmr_val  = PULSE_LOAD;
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end
      end
      default: ;
    endcase
  end

  sr_drv_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      done_q <= 1'b0;
`ifdef SR_LATCH_DRIVER_READBACK_EN
      set_lat <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            // s and r are complements here. They are only ever both driven
            // after a GAP of at least one cycle, so they never overlap.
            s_q   <= cmd_set;
            r_q   <= ~cmd_set;
            state <= ST_PULSE;
`ifdef SR_LATCH_DRIVER_READBACK_EN
            set_lat <= cmd_set;
`endif
          end
        end
        ST_PULSE: begin
          if (tmr_zero) begin
            s_q   <= 1'b0;
            r_q   <= 1'b0;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_zero) begin
`ifdef SR_LATCH_DRIVER_READBACK_EN
            state <= ST_CHECK;
`else
            state  <= ST_IDLE;
            done_q <= 1'b1;
`endif
          end
        end
`ifdef SR_LATCH_DRIVER_READBACK_EN
        ST_CHECK: begin
          if ((q_fb != set_lat) || (qbar_fb != ~set_lat)) err_q <= 1'b1;
          state  <= ST_IDLE;
          done_q <= 1'b1;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign s         = s_q;
  assign r         = r_q;
  assign done      = done_q;

`ifdef SR_LATCH_DRIVER_READBACK_EN
  assign err = err_q;
`else
  logic unused_fb;
  assign unused_fb = q_fb ^ qbar_fb;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed-vector bench for sr_latch_driver.
// It instantiates one DUT with the default parameters and one with
// PULSE_CYC=1, GAP_CYC=3.
// Optional macro: SR_LATCH_DRIVER_READBACK_EN (shifts done by one cycle and
// enables the err checks).
module tb_sr_latch_driver;

`ifdef SR_LATCH_DRIVER_READBACK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int PC  = 2;
  localparam int GC  = 1;
  localparam int PC2 = 1;
  localparam int GC2 = 3;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_set, cmd_ready, s, r, q_fb, qbar_fb, done, err;
  logic cmd_valid2, cmd_set2, cmd_ready2, s2, r2, q_fb2, qbar_fb2, done2, err2;
  logic lat_q, lat_q2, bad_q, exp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sr_latch_driver dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_set(cmd_set), .s(s), .r(r), .q_fb(q_fb), .qbar_fb(qbar_fb),
    .done(done), .err(err)
  );

  sr_latch_driver #(.PULSE_CYC(PC2), .GAP_CYC(GC2)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_set(cmd_set2), .s(s2), .r(r2), .q_fb(q_fb2), .qbar_fb(qbar_fb2),
    .done(done2), .err(err2)
  );

  // Behavioural SR latches driven by the DUT outputs.
  // bad_q forces a wrong Q readback on the first DUT.
  always @(posedge clk) begin
    if (rst) lat_q <= 1'b0;
    else if (s) lat_q <= 1'b1;
    else if (r) lat_q <= 1'b0;
    if (rst) lat_q2 <= 1'b0;
    else if (s2) lat_q2 <= 1'b1;
    else if (r2) lat_q2 <= 1'b0;
  end
  assign q_fb     = bad_q ? 1'b0 : lat_q;
  assign qbar_fb  = ~lat_q;
  assign q_fb2    = lat_q2;
  assign qbar_fb2 = ~lat_q2;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // s and r must never be high together, so this is checked on every cycle.
  always @(negedge clk) begin
    check_eq("s_r_excl", s & r, 1'b0);
    check_eq("s2_r2_excl", s2 & r2, 1'b0);
  end

  // The task starts in an IDLE cycle, and the command is accepted at the
  // next edge. It returns in the done cycle with cmd_valid low. A caller that
  // invokes it again straight away gets a back-to-back acceptance in the
  // done cycle.
  task automatic run_op(input logic set_v, input bit disturb);
    cmd_valid = 1'b1;
    cmd_set   = set_v;
    tick;
    cmd_valid = 1'b0;
    for (int c = 1; c <= PC + GC + CHK; c++) begin
      check_eq("op_s",     s,         (c <= PC) && set_v);
      check_eq("op_r",     r,         (c <= PC) && !set_v);
      check_eq("op_ready", cmd_ready, 1'b0);
      check_eq("op_done",  done,      1'b0);
      check_eq("op_err",   err,       exp_err);
      if (disturb) begin
        cmd_valid = c[0];
        cmd_set   = ~set_v;
      end
      tick;
    end
    if (CHK == 1 && bad_q && set_v) exp_err = 1'b1;
    check_eq("done_pulse", done,      1'b1);
    check_eq("done_ready", cmd_ready, 1'b1);
    check_eq("done_s",     s,         1'b0);
    check_eq("done_r",     r,         1'b0);
    check_eq("done_err",   err,       exp_err);
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_set = 1'b0;
    cmd_valid2 = 1'b0; cmd_set2 = 1'b0; bad_q = 1'b0; exp_err = 1'b0;
    tick;
    tick;
    rst = 1'b0;

    // Reset state
    check_eq("rst_s",     s,         1'b0);
    check_eq("rst_r",     r,         1'b0);
    check_eq("rst_done",  done,      1'b0);
    check_eq("rst_err",   err,       1'b0);
    check_eq("rst_ready", cmd_ready, 1'b1);
    check_eq("rst_ready2", cmd_ready2, 1'b1);

    // PULSE_CYC=1, GAP_CYC=3: one r cycle, three low cycles, then done
    cmd_valid2 = 1'b1;
    cmd_set2   = 1'b0;
    tick;
    cmd_valid2 = 1'b0;
    for (int c = 1; c <= PC2 + GC2 + CHK; c++) begin
      check_eq("p1_r",     r2,         c <= PC2);
      check_eq("p1_s",     s2,         1'b0);
      check_eq("p1_done",  done2,      1'b0);
      check_eq("p1_ready", cmd_ready2, 1'b0);
      tick;
    end
    check_eq("p1_done_pulse", done2,      1'b1);
    check_eq("p1_done_ready", cmd_ready2, 1'b1);
    tick;
    check_eq("p1_done_once", done2, 1'b0);

    // Single set command with default timing
    run_op(1'b1, 1'b0);
    tick;
    check_eq("done_once", done, 1'b0);

    // Back-to-back: set, reset, set with no idle cycles in between
    run_op(1'b1, 1'b0);
    run_op(1'b0, 1'b0);
    run_op(1'b1, 1'b0);
    tick;
    check_eq("b2b_done_once", done, 1'b0);

    // Toggle cmd_valid and flip cmd_set during a reset operation
    run_op(1'b0, 1'b1);
    tick;
    check_eq("dist_idle_s", s, 1'b0);
    check_eq("dist_idle_r", r, 1'b0);

    // Reset in the second PULSE cycle aborts the operation
    cmd_valid = 1'b1;
    cmd_set   = 1'b1;
    tick;
    cmd_valid = 1'b0;
    check_eq("abort_c1_s", s, 1'b1);
    tick;
    check_eq("abort_c2_s", s, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_eq("abort_s",     s,         1'b0);
    check_eq("abort_r",     r,         1'b0);
    check_eq("abort_ready", cmd_ready, 1'b1);
    for (int i = 0; i < PC + GC + CHK + 2; i++) begin
      check_eq("abort_no_done", done, 1'b0);
      check_eq("abort_idle_s",  s,    1'b0);
      tick;
    end

    // Bad Q readback on a set operation sets a sticky err (when enabled)
    bad_q = 1'b1;
    run_op(1'b1, 1'b0);
    bad_q = 1'b0;
    run_op(1'b0, 1'b0);
    run_op(1'b1, 1'b0);
    tick;
    check_eq("err_sticky", err, exp_err);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_err = 1'b0;
    check_eq("err_cleared", err, 1'b0);
    check_eq("err_rst_ready", cmd_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 The block SHALL have parameter PULSE_CYC, default 2, giving the active S/R pulse width in clock cycles (legal range 1..255).
REQ-002 The block SHALL have parameter GAP_CYC, default 1, giving the both-low recovery cycles after each pulse (legal range 1..255).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high; ports: clk input 1 (rising-edge clock), rst input 1 (sync active-high reset).
REQ-004 The block SHALL have the following ports: cmd_valid input 1 (command request); cmd_ready output 1 (accepting commands); cmd_set input 1 (1=set latch, 0=reset latch).
REQ-005 The block SHALL have the following ports: s output 1 (latch set drive); r output 1 (latch reset drive); q_fb input 1 (latch Q readback); qbar_fb input 1 (latch Q' readback).
REQ-006 The block SHALL have the following ports: done output 1 (one-cycle completion pulse); err output 1 (sticky readback mismatch).

Function
REQ-007 The FSM SHALL have the states IDLE, PULSE, GAP and CHECK; CHECK exists only when the macro is defined.
REQ-008 cmd_ready SHALL be 1 only in IDLE, and a command SHALL be accepted on a clock edge where cmd_valid and cmd_ready are both 1.
REQ-009 On acceptance the block SHALL latch cmd_set internally, and later changes to cmd_set or cmd_valid SHALL be ignored until the next acceptance.
REQ-010 In PULSE, the block SHALL drive s=1 (latched set) or r=1 (latched reset) for exactly PULSE_CYC consecutive cycles, starting the cycle after acceptance.
REQ-011 s and r SHALL be registered outputs and SHALL never be 1 in the same cycle, including across reset and back-to-back commands.
REQ-012 In GAP, the block SHALL hold s=0 and r=0 for exactly GAP_CYC cycles.
REQ-013 After GAP, the block SHALL go to CHECK if the macro is defined, otherwise to IDLE.
REQ-014 done SHALL pulse for one cycle in the first IDLE cycle after the operation, the same cycle cmd_ready returns to 1.
REQ-015 Timing example (PULSE_CYC=2, GAP_CYC=1, accept at edge 0): s=1 in cycles 1-2, gap in cycle 3, done in cycle 4 (macro off) or cycle 5 (macro on).
REQ-016 A command held valid across done SHALL be accepted in the done cycle, so back-to-back operations lose no cycles.
REQ-017 The pulse and gap counters SHALL be sized with $clog2 of the parameter and SHALL count down to 0 without wrap-around.
REQ-018 q_fb and qbar_fb SHALL be sampled without a synchronizer, since the latch is driven only by this block's registered outputs and has settled by CHECK.

Reset
REQ-019 When rst=1 at an edge, state SHALL become IDLE and the outputs SHALL become s=0, r=0, done=0, err=0, cmd_ready=1 (in the following cycle).
REQ-020 A reset mid-PULSE or mid-GAP SHALL abort the operation: s and r drop at that edge, done does not pulse, and the command is discarded.
REQ-021 err SHALL be cleared only by reset.

Configuration
REQ-022 With SR_LATCH_DRIVER_READBACK_EN defined, CHECK SHALL last one cycle and compare q_fb==cmd_set and qbar_fb==~cmd_set; any mismatch (including q_fb==qbar_fb) sets err.
REQ-023 Without SR_LATCH_DRIVER_READBACK_EN, CHECK SHALL be absent, err SHALL be tied to 0, and q_fb and qbar_fb SHALL be unused.

Structure
REQ-024 Package sr_drv_pkg SHALL hold the state enum and the PULSE_CYC and GAP_CYC defaults.
REQ-025 A sub-module sr_drv_timer (a loadable down-counter with a zero flag) SHALL be instantiated once and shared by PULSE and GAP.

Verification
REQ-026 Reset, then cmd_valid=1, cmd_set=1, defaults -> s=1 in cycles 1-2, r=0 throughout, done in cycle 4 (macro off) or cycle 5 (macro on).
REQ-027 Two back-to-back commands (set, then reset) with cmd_valid held high -> second accepted in the done cycle; s and r never both 1.
REQ-028 rst asserted in cycle 2 of a PULSE -> s=0 next cycle, no done pulse, cmd_ready=1.
REQ-029 Macro on, bench latch model driving q_fb=0 after a set command -> err=1 and stays 1 through later good commands until rst.
REQ-030 PULSE_CYC=1, GAP_CYC=3 -> single-cycle pulse, three both-low cycles, then done.
REQ-031 cmd_valid toggled during PULSE with cmd_set flipped -> ignored, cmd_ready=0, original operation completes unchanged.
